// File: rtl/linear_proj_pkg.sv
// Shared constants, FSM state type and a width helper for the linear-projection controller.
package linear_proj_pkg;

  // Output tile grid of one Q/K/V projection
  localparam int ROW_SIZE_MAT_C  = 2;
  localparam int COL_SIZE_MAT_C  = 2;
  // Index of the final tile in the grid
  localparam int MAX_FLAG        = ROW_SIZE_MAT_C * COL_SIZE_MAT_C - 1;

  // Inner-dimension blocking
  localparam int INNER_DIMENSION = 12;
  localparam int BLOCK_SIZE      = 4;
  localparam int INNER_BLOCKS_C  = INNER_DIMENSION / BLOCK_SIZE;

  // BRAM characteristics
  localparam int RD_LATENCY_C    = 2;
  localparam int ADDR_WIDTH_A_C  = 3;
  localparam int ADDR_WIDTH_B_C  = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_MM = 3'd2,
    S_OUTPUT  = 3'd3,
    S_DONE    = 3'd4
  } lp_state_e;

  // Index width that never collapses to zero bits
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/linear_proj_ctrl_if.sv
// BRAM read, matmul strobe and tile-output handshake bundle of the projection controller.
interface linear_proj_ctrl_if
  import linear_proj_pkg::*;
#(
  parameter int AW_A  = ADDR_WIDTH_A_C,
  parameter int AW_B  = ADDR_WIDTH_B_C,
  parameter int ROW_W = clog2_min1(ROW_SIZE_MAT_C),
  parameter int COL_W = clog2_min1(COL_SIZE_MAT_C)
) ();

  logic            bram_a_en;
  logic [AW_A-1:0] bram_a_addr;
  logic            bram_b_en;
  logic [AW_B-1:0] bram_b_addr;
  logic            mm_en;
  logic            mm_first;
  logic            mm_last;
  logic            mm_done;
  logic            out_valid;
  logic            out_ready;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;

  // Controller side
  modport master (
    output bram_a_en, bram_a_addr, bram_b_en, bram_b_addr,
    output mm_en, mm_first, mm_last,
    input  mm_done,
    output out_valid, out_row, out_col,
    input  out_ready
  );

  // Datapath / writer side
  modport slave (
    input  bram_a_en, bram_a_addr, bram_b_en, bram_b_addr,
    input  mm_en, mm_first, mm_last,
    output mm_done,
    input  out_valid, out_row, out_col,
    output out_ready
  );

endinterface

// File: rtl/lp_valid_delay.sv
// Shift register aligning {en, first, last} read strobes with BRAM read data.
module lp_valid_delay
  import linear_proj_pkg::*;
#(
  parameter int DEPTH = RD_LATENCY_C
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] d_i,
  output logic [2:0] q_o,
  output logic       busy_o
);

  logic [DEPTH-1:0][2:0] stage_q;

  // Shift the strobe triple one stage per cycle; synchronous clear empties the line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // A stage is occupied when its en bit is set
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_o = busy_o | stage_q[i][2];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/linear_proj_ctrl.sv
// Tile sequencer: walks row x col tiles, issues inner-block BRAM reads,
// waits for the matmul array and hands each tile to the writer.
module linear_proj_ctrl
  import linear_proj_pkg::*;
#(
  parameter int ROW_TILES    = ROW_SIZE_MAT_C,
  parameter int COL_TILES    = COL_SIZE_MAT_C,
  parameter int INNER_BLOCKS = INNER_BLOCKS_C,
  parameter int RD_LATENCY   = RD_LATENCY_C,
  parameter int ADDR_WIDTH_A = ADDR_WIDTH_A_C,
  parameter int ADDR_WIDTH_B = ADDR_WIDTH_B_C,
  parameter int ROW_W        = clog2_min1(ROW_SIZE_MAT_C),
  parameter int COL_W        = clog2_min1(COL_SIZE_MAT_C)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  linear_proj_ctrl_if.master bus_if
);

  localparam int KW = clog2_min1(INNER_BLOCKS);
  localparam logic [KW-1:0]           K_LAST   = KW'(INNER_BLOCKS - 1);
  localparam logic [ROW_W-1:0]        ROW_LAST = ROW_W'(ROW_TILES - 1);
  localparam logic [COL_W-1:0]        COL_LAST = COL_W'(COL_TILES - 1);
  localparam logic [ADDR_WIDTH_A-1:0] IB_A     = ADDR_WIDTH_A'(INNER_BLOCKS);
  localparam logic [ADDR_WIDTH_B-1:0] IB_B     = ADDR_WIDTH_B'(INNER_BLOCKS);

  lp_state_e state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  // Tile base addresses replace row*INNER_BLOCKS / col*INNER_BLOCKS
  logic [ADDR_WIDTH_A-1:0] a_base_q, a_base_d;
  logic [ADDR_WIDTH_B-1:0] b_base_q, b_base_d;

  logic                    issue_q, first_q, last_q;
  logic [ADDR_WIDTH_A-1:0] a_addr_q;
  logic [ADDR_WIDTH_B-1:0] b_addr_q;
  logic                    out_valid_q, busy_q, done_q;
  logic [ROW_W-1:0]        out_row_q;
  logic [COL_W-1:0]        out_col_q;
  logic [2:0]              dly_q_s;
  logic                    pipe_busy_s;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and tile/step counter logic
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    row_d    = row_q;
    col_d    = col_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_ISSUE;
          k_d      = '0;
          row_d    = '0;
          col_d    = '0;
          a_base_d = '0;
          b_base_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = S_WAIT_MM;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_WAIT_MM: begin
        // A completion is only trusted once every read strobe has left the delay line
        if (bus_if.mm_done && !pipe_busy_s) state_d = S_OUTPUT;
        else                                state_d = S_WAIT_MM;
      end
      S_OUTPUT: begin
        if (bus_if.out_ready) begin
          if (col_q == COL_LAST) begin
            col_d    = '0;
            b_base_d = '0;
            row_d    = row_q + ROW_W'(1);
            a_base_d = a_base_q + IB_A;
          end else begin
            col_d    = col_q + COL_W'(1);
            b_base_d = b_base_q + IB_B;
          end
          if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
            state_d  = S_DONE;
            row_d    = '0;
            a_base_d = '0;
          end else begin
            state_d = S_ISSUE;
            k_d     = '0;
          end
        end else begin
          state_d = S_OUTPUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter and base-address registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
    end else begin
      k_q      <= k_d;
      row_q    <= row_d;
      col_q    <= col_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
    end
  end

  // Output registers loaded from next-state so they line up with the state they describe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      issue_q     <= (state_d == S_ISSUE);
      first_q     <= (state_d == S_ISSUE) && (k_d == '0);
      last_q      <= (state_d == S_ISSUE) && (k_d == K_LAST);
      a_addr_q    <= (state_d == S_ISSUE) ? a_base_d + ADDR_WIDTH_A'(k_d) : '0;
      b_addr_q    <= (state_d == S_ISSUE) ? b_base_d + ADDR_WIDTH_B'(k_d) : '0;
      out_valid_q <= (state_d == S_OUTPUT);
      out_row_q   <= (state_d == S_OUTPUT) ? row_d : '0;
      out_col_q   <= (state_d == S_OUTPUT) ? col_d : '0;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  lp_valid_delay #(.DEPTH(RD_LATENCY)) u_delay (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    ({issue_q, first_q, last_q}),
    .q_o    (dly_q_s),
    .busy_o (pipe_busy_s)
  );

  assign bus_if.bram_a_en   = issue_q;
  assign bus_if.bram_a_addr = a_addr_q;
  assign bus_if.bram_b_en   = issue_q;
  assign bus_if.bram_b_addr = b_addr_q;
  assign bus_if.mm_en       = dly_q_s[2];
  assign bus_if.mm_first    = dly_q_s[1];
  assign bus_if.mm_last     = dly_q_s[0];
  assign bus_if.out_valid   = out_valid_q;
  assign bus_if.out_row     = out_row_q;
  assign bus_if.out_col     = out_col_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

endmodule
